// File: rtl/oam_dma_engine.sv
// OAM sprite DMA engine: a CPU write to $4014 halts the CPU and copies the
// 256-byte page {page,00..FF} into OAM, one read/write CPU-cycle pair per byte.
module oam_dma_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic [7:0]  mem_din,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  logic [2:0] state_r;
  logic       par_r;
  logic [7:0] index_r;
  logic [7:0] page_r;
  logic [7:0] wdata_r;
  logic       trigger_s;

  assign trigger_s = cpu_we && (cpu_addr == 16'h4014);

  // Sequencer; triggers are only honoured from IDLE, so a write during a DMA is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      par_r   <= 1'b0;
      index_r <= 8'd0;
      page_r  <= 8'd0;
      wdata_r <= 8'd0;
    end else if (cpu_en) begin
      par_r <= ~par_r;
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_r <= ST_HALT;
            page_r  <= cpu_dout;
            index_r <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        // par=1 now means the following CPU cycle is even, which is where reads must land
        ST_HALT:  state_r <= par_r ? ST_READ : ST_ALIGN;
        ST_ALIGN: state_r <= ST_READ;
        ST_READ: begin
          state_r <= ST_WRITE;
          wdata_r <= mem_din;
        end
        ST_WRITE: begin
          if (index_r == 8'hFF) begin
            state_r <= ST_IDLE;
            index_r <= 8'd0;
          end else begin
            state_r <= ST_READ;
            index_r <= index_r + 8'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Bus-side outputs decoded from the registered state.
  always_comb begin
    dma_active = 1'b0;
    dma_rd     = 1'b0;
    dma_addr   = 16'h0000;
    if (state_r == ST_IDLE) begin
      dma_active = 1'b0;
      dma_addr   = 16'h0000;
    end else begin
      dma_active = 1'b1;
      dma_addr   = {page_r, index_r};
    end
    if (state_r == ST_READ) begin
      dma_rd = 1'b1;
    end else begin
      dma_rd = 1'b0;
    end
  end

  assign oam_addr  = index_r;
  assign oam_wdata = wdata_r;
  assign oam_we    = (state_r == ST_WRITE) && cpu_en;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: alignment, duty-cycled cpu_en, re-trigger,
// mid-transfer reset and non-trigger writes, with a small per-byte scoreboard.
module tb_oam_dma_engine;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  mem_din;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  oam_dma_engine dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_we(cpu_we), .mem_din(mem_din),
    .dma_active(dma_active), .dma_addr(dma_addr), .dma_rd(dma_rd),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we)
  );

  // memory model: each byte holds the low byte of its address
  assign mem_din = dma_addr[7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int div = 1;
  int phase = 0;
  bit tb_par = 1'b0;
  bit last_en = 1'b0;
  logic [7:0] pg_exp = 8'h00;
  int idx_exp, we_pulses, act_cycles;
  int err_order, err_addr, err_par, err_we, err_hold;
  logic [42:0] snap;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    idx_exp = 0; we_pulses = 0; act_cycles = 0;
    err_order = 0; err_addr = 0; err_par = 0; err_we = 0; err_hold = 0;
  endtask

  // one clk: set cpu_en, observe pre-edge outputs, take the edge, track parity
  task automatic tick();
    @(negedge clk);
    cpu_en = (phase == div - 1);
    phase = (phase + 1) % div;
    last_en = cpu_en;
    #1;
    if (cpu_en) begin
      if (dma_active) act_cycles++;
      if (oam_we) begin
        if (oam_addr !== idx_exp[7:0] || oam_wdata !== idx_exp[7:0]) err_order++;
        we_pulses++;
        idx_exp++;
      end
      if (dma_rd) begin
        if (tb_par) err_par++;
        if (dma_addr !== {pg_exp, idx_exp[7:0]}) err_addr++;
      end
    end else begin
      if (oam_we) err_we++;
      snap = {dma_active, dma_addr, dma_rd, oam_addr, oam_wdata};
    end
    @(posedge clk);
    #1;
    if (rst) tb_par = 1'b0;
    else if (last_en) tb_par = ~tb_par;
    if (!last_en && !rst && snap !== {dma_active, dma_addr, dma_rd, oam_addr, oam_wdata}) err_hold++;
  endtask

  // advance to and through the next cpu_en edge
  task automatic cpu_step();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (last_en) break;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_we = 1'b1;
    cpu_step();
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
  endtask

  // trigger a DMA from page pg; odd=1 triggers one CPU cycle later (ALIGN needed)
  task automatic run_dma(input logic [7:0] pg, input bit odd, input int retrig_at, input int rst_at);
    bit done = 1'b0;
    bit retrig_done = 1'b0;
    clear_stats();
    pg_exp = pg;
    for (int k = 0; k < 4 && tb_par != odd; k++) cpu_step();
    cpu_write(16'h4014, pg);
    for (int n = 0; n < 600 && !done; n++) begin
      if (rst_at >= 0 && we_pulses == rst_at) begin
        rst = 1'b1;
        cpu_step();
        rst = 1'b0;
        done = 1'b1;
      end else if (retrig_at >= 0 && we_pulses == retrig_at && !retrig_done) begin
        retrig_done = 1'b1;
        cpu_write(16'h4014, 8'h07);
      end else begin
        cpu_step();
      end
      if (!dma_active) done = 1'b1;
    end
    check("dma_terminates", done, 1);
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00;
    clear_stats();
    repeat (3) tick();
    check("rst_dma_active", dma_active, 0);
    check("rst_dma_rd", dma_rd, 0);
    check("rst_oam_we", oam_we, 0);
    check("rst_dma_addr", dma_addr, 16'h0000);
    check("rst_oam_addr", oam_addr, 8'h00);
    check("rst_oam_wdata", oam_wdata, 8'h00);
    rst = 1'b0;

    cpu_write(16'h4015, 8'h02);
    check("no_trig_4015", dma_active, 0);
    cpu_write(16'h2014, 8'h02);
    check("no_trig_2014", dma_active, 0);

    run_dma(8'h02, 1'b0, -1, -1);
    check("even_active_cycles", act_cycles, 513);
    check("even_we_pulses", we_pulses, 256);
    check("even_addr_errs", err_addr, 0);
    check("even_order_errs", err_order, 0);
    check("even_read_parity", err_par, 0);
    check("even_idle_addr", dma_addr, 16'h0000);

    run_dma(8'h02, 1'b1, -1, -1);
    check("odd_active_cycles", act_cycles, 514);
    check("odd_we_pulses", we_pulses, 256);
    check("odd_addr_errs", err_addr, 0);
    check("odd_order_errs", err_order, 0);
    check("odd_read_parity", err_par, 0);

    div = 3; phase = 0;
    run_dma(8'h02, 1'b0, -1, -1);
    check("duty_we_pulses", we_pulses, 256);
    check("duty_active_cycles", act_cycles, 513);
    check("duty_we_off_en", err_we, 0);
    check("duty_hold_errs", err_hold, 0);
    check("duty_order_errs", err_order, 0);
    div = 1; phase = 0;

    run_dma(8'h02, 1'b0, 100, -1);
    check("retrig_we_pulses", we_pulses, 256);
    check("retrig_page_kept", err_addr, 0);
    check("retrig_active_cycles", act_cycles, 513);

    run_dma(8'h02, 1'b0, -1, 50);
    check("midrst_dma_active", dma_active, 0);
    check("midrst_oam_addr", oam_addr, 8'h00);
    check("midrst_oam_wdata", oam_wdata, 8'h00);
    repeat (10) cpu_step();
    check("midrst_no_more_we", we_pulses, 50);

    run_dma(8'h03, 1'b0, -1, -1);
    check("after_rst_we_pulses", we_pulses, 256);
    check("after_rst_addr_errs", err_addr, 0);
    check("after_rst_order_errs", err_order, 0);
    check("after_rst_last_idx", idx_exp, 256);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/oam_dma_engine.md
OAM_DMA_ENGINE -- requirements
Module: oam_dma_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_en  in  1  one-clk strobe marking each CPU cycle boundary; all state changes occur only on clk edges where cpu_en=1
- cpu_addr  in  16  CPU bus address
- cpu_dout  in  8  CPU write data
- cpu_we  in  1  CPU write strobe
- mem_din  in  8  read data returned from RAM/PPU/cart as selected by the address decoder for dma_addr
- dma_active  out  1  DMA owns bus; CPU halted (drives CPU RDY low)
- dma_addr  out  16  bus address driven to the address decoder while dma_active
- dma_rd  out  1  DMA read request
- oam_addr  out  8  OAM write index
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write strobe, one clk wide

Function
REQ-003 The block SHALL trigger on a clk edge with cpu_en=1, cpu_we=1 and cpu_addr=16'h4014, capturing cpu_dout into an 8-bit page register.
REQ-004 A trigger while dma_active=1 SHALL be ignored, leaving page, index and state unchanged.
REQ-005 The block SHALL implement a state machine with states IDLE, HALT, ALIGN, READ and WRITE.
REQ-006 State transitions:
- IDLE->HALT on trigger
- HALT->READ if the next CPU cycle is even, else HALT->ALIGN
- ALIGN->READ
- READ->WRITE
- WRITE->READ while index!=255
- WRITE->IDLE when index=255
REQ-007 The block SHALL keep a parity bit par that toggles on every cpu_en edge; reset value is 0. par is the parity of the current CPU cycle.
REQ-008 In HALT, the "next cycle even" test SHALL be par=1.
REQ-009 Every READ cycle SHALL therefore have par=0.
REQ-010 The block SHALL keep an 8-bit index that is 0 on entry to HALT and increments on each WRITE->READ transition; it wraps only via the return to IDLE.
REQ-011 In READ, the block SHALL drive dma_rd=1 and dma_addr={page,index}.
REQ-012 In all states other than READ, dma_rd SHALL be 0; dma_addr SHALL be 16'h0000 in IDLE and hold {page,index} otherwise.
REQ-013 On the cpu_en edge leaving READ, the block SHALL latch mem_din into oam_wdata.
REQ-014 oam_wdata SHALL hold its value until the next latch.
REQ-015 oam_we SHALL equal (state=WRITE)&cpu_en, giving exactly one clk pulse per WRITE cycle.
REQ-016 oam_addr SHALL equal index.
REQ-017 dma_active SHALL be 1 in every state except IDLE and 0 in IDLE.
REQ-018 Total dma_active duration SHALL be 513 CPU cycles when no ALIGN occurs and 514 CPU cycles when ALIGN occurs.
REQ-019 The block SHALL perform exactly 256 OAM writes per DMA, covering addresses 0..255 in order.
REQ-020 When cpu_en=0, all registers SHALL hold their values.
REQ-021 Outputs driven from state SHALL be stable throughout a CPU cycle.
REQ-022 A trigger on the same edge that WRITE->IDLE completes SHALL be ignored, because dma_active is still 1 on that edge.

Reset
REQ-023 rst SHALL take priority over cpu_en and over any trigger.
REQ-024 While rst=1, the block SHALL reset to: state=IDLE, par=0, index=0, page=0, oam_wdata=0.
REQ-025 Output values under reset SHALL be: dma_active=0, dma_rd=0, oam_we=0, dma_addr=0, oam_addr=0.
REQ-026 rst asserted mid-DMA SHALL abort the transfer immediately on that edge, with no further oam_we pulses.
REQ-027 After rst deasserts, a new trigger SHALL start a full 256-byte DMA from index 0.

Verification
REQ-028 Even-aligned DMA: write 8'h02 to $4014 such that HALT has par=1, with mem_din modelled as the low byte of dma_addr -> no ALIGN; 513 dma_active cycles; dma_addr 16'h0200..16'h02FF; oam_addr 0..255; oam_wdata 0..255.
REQ-029 Odd-aligned DMA: trigger one CPU cycle later than in REQ-028 -> one ALIGN cycle; 514 dma_active cycles; every READ has par=0.
REQ-030 cpu_en duty: drive cpu_en high 1 clk in 3 -> exactly 256 oam_we pulses, each one clk wide; no state change on clk edges with cpu_en=0.
REQ-031 Re-trigger: write 8'h07 to $4014 at index=100 during an active DMA -> page remains 8'h02 and the transfer completes unchanged.
REQ-032 Reset mid-operation: assert rst at index=50 -> the next edge gives dma_active=0 and no further oam_we; a subsequent trigger with 8'h03 transfers 16'h0300..16'h03FF completely.
REQ-033 Non-trigger write: write to $4015 and to $2014 -> dma_active stays 0.
